// File: rtl/pid_pkg.sv
// pid_pkg -- shared widths and FSM state encoding for the incremental PID
// increment calculator (pid_incr_calc) and its output clamp (pid_sat).
package pid_pkg;

  localparam int ERR_W   = 10;            // signed error samples e(k), e(k-1), e(k-2)
  localparam int GAIN_W  = 8;             // unsigned gains kp, ki, kd
  localparam int ACC_W   = 24;            // signed product accumulator
  localparam int U_W     = 10;            // unsigned duty command

  localparam int DIFFP_W = ERR_W + 1;     // e0 - e1
  localparam int DIFFD_W = ERR_W + 2;     // e0 - 2*e1 + e2
  localparam int OPB_W   = GAIN_W + 1;    // gain zero-extended into a signed operand
  localparam int PROD_W  = DIFFD_W + OPB_W;
  localparam int SUM_W   = 26;            // u(k-1) + shifted increment

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL_P,
    ST_MUL_I,
    ST_MUL_D,
    ST_UPDATE
  } pid_state_e;

endpackage

// File: rtl/pid_sat.sv
// pid_sat -- purely combinational clamp of the signed update sum into the
// unsigned duty range [0, OUT_MAX].
//   sum : signed SUM_W-bit u(k-1) + increment
//   sat : clamped U_W-bit duty value
module pid_sat
  import pid_pkg::*;
#(
  parameter int OUT_MAX = 1023
) (
  input  logic signed [SUM_W-1:0] sum,
  output logic        [U_W-1:0]   sat
);

  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(OUT_MAX);

  always_comb begin
    if (sum < 0)
      sat = '0;
    else if (sum > MAX_S)
      sat = U_W'(OUT_MAX);
    else
      sat = sum[U_W-1:0];
  end

endmodule

// File: rtl/pid_incr_calc.sv
// pid_incr_calc -- incremental (velocity-form) PID controller:
//   u(k) = clamp(u(k-1) + (Kp*(e0-e1) + Ki*e0 + Kd*(e0-2*e1+e2)) >>> FRAC_BITS)
// One shared signed multiplier produces one product per cycle, sequenced by
// IDLE -> MUL_P -> MUL_I -> [MUL_D] -> UPDATE -> IDLE.
// Build option: define PID_DERIV_EN to include the derivative term (MUL_D
// state, kd used, latency 5); undefined, kd is ignored and latency is 4.
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   sample_valid     strobe: ek0..ek2 and kp..kd valid this cycle
//   ek0, ek1, ek2    signed e(k), e(k-1), e(k-2)
//   kp, ki, kd       unsigned gains, Q(8-FRAC_BITS).FRAC_BITS
//   clr              synchronous clear of controller state (overrun kept)
//   u                clamped duty command, holds between updates
//   u_valid          one-cycle pulse when u is updated
//   busy             computation in flight
//   overrun          sticky: a strobe arrived while busy and was dropped
module pid_incr_calc
  import pid_pkg::*;
#(
  parameter int FRAC_BITS = 4,
  parameter int OUT_MAX   = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic signed [ERR_W-1:0]  ek0,
  input  logic signed [ERR_W-1:0]  ek1,
  input  logic signed [ERR_W-1:0]  ek2,
  input  logic        [GAIN_W-1:0] kp,
  input  logic        [GAIN_W-1:0] ki,
  input  logic        [GAIN_W-1:0] kd,
  input  logic                     clr,
  output logic        [U_W-1:0]    u,
  output logic                     u_valid,
  output logic                     busy,
  output logic                     overrun
);

  pid_state_e               state_q, state_d;
  logic signed [ERR_W-1:0]  e0_q, e1_q, e2_q;
  logic        [GAIN_W-1:0] kp_q, ki_q, kd_q;
  logic signed [ACC_W-1:0]  acc_q;

  logic signed [DIFFP_W-1:0] diff_p;
  logic signed [DIFFD_W-1:0] diff_d;
  logic signed [DIFFD_W-1:0] op_a;
  logic signed [OPB_W-1:0]   op_b;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   acc_shr;
  logic signed [SUM_W-1:0]   sum_d;
  logic        [U_W-1:0]     u_sat;

  assign diff_p = DIFFP_W'(e0_q) - DIFFP_W'(e1_q);
  assign diff_d = DIFFD_W'(e0_q) - (DIFFD_W'(e1_q) <<< 1) + DIFFD_W'(e2_q);

`ifndef PID_DERIV_EN
  // Derivative path is compiled out; keep its inputs visibly consumed.
  logic unused_deriv;
  assign unused_deriv = ^{kd_q, diff_d};
`endif

  // Operand mux for the single shared multiplier.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state_q)
      ST_MUL_P: begin
        op_a = DIFFD_W'(diff_p);
        op_b = $signed({1'b0, kp_q});
      end
      ST_MUL_I: begin
        op_a = DIFFD_W'(e0_q);
        op_b = $signed({1'b0, ki_q});
      end
      ST_MUL_D: begin
        op_a = diff_d;
        op_b = $signed({1'b0, kd_q});
      end
      default: ;
    endcase
  end

  assign prod = PROD_W'(op_a) * PROD_W'(op_b);

  // >>> on a signed value floors toward negative infinity.
  assign acc_shr = acc_q >>> FRAC_BITS;
  assign sum_d   = $signed({{(SUM_W-U_W){1'b0}}, u})
                 + $signed({{(SUM_W-ACC_W){acc_shr[ACC_W-1]}}, acc_shr});

  pid_sat #(.OUT_MAX(OUT_MAX)) u_pid_sat (
    .sum (sum_d),
    .sat (u_sat)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (sample_valid) state_d = ST_MUL_P;
      ST_MUL_P:  state_d = ST_MUL_I;
`ifdef PID_DERIV_EN
      ST_MUL_I:  state_d = ST_MUL_D;
      ST_MUL_D:  state_d = ST_UPDATE;
`else
      ST_MUL_I:  state_d = ST_UPDATE;
`endif
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (clr) state_d = ST_IDLE;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      e0_q    <= '0;
      e1_q    <= '0;
      e2_q    <= '0;
      kp_q    <= '0;
      ki_q    <= '0;
      kd_q    <= '0;
      acc_q   <= '0;
      u       <= '0;
      u_valid <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      u_valid <= 1'b0;
      // A strobe during a computation is dropped; clr takes precedence.
      if (sample_valid && busy && !clr) overrun <= 1'b1;
      if (clr) begin
        acc_q <= '0;
        u     <= '0;
        busy  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (sample_valid) begin
              e0_q  <= ek0;
              e1_q  <= ek1;
              e2_q  <= ek2;
              kp_q  <= kp;
              ki_q  <= ki;
              kd_q  <= kd;
              acc_q <= '0;
              busy  <= 1'b1;
            end
          end
          ST_MUL_P, ST_MUL_I, ST_MUL_D: acc_q <= acc_q + ACC_W'(prod);
          ST_UPDATE: begin
            u       <= u_sat;
            u_valid <= 1'b1;
            busy    <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/pid_incr_calc.md
PID_INCR_CALC -- requirements
Module: pid_incr_calc

Interface
REQ-001 SHALL have parameter FRAC_BITS, default 4, gain fractional bits (gains are unsigned Q(8-FRAC_BITS).FRAC_BITS).
REQ-002 SHALL have parameter OUT_MAX, default 1023, upper clamp of the duty output.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic rises on posedge clk.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port sample_valid, input, 1, one-cycle strobe: ek0/ek1/ek2 are valid this cycle.
REQ-006 SHALL have ports ek0, ek1 and ek2, input, 10 each, signed e(k), e(k-1) and e(k-2) from the error stage.
REQ-007 SHALL have ports kp, ki and kd, input, 8 each, unsigned gains; they are sampled together with the errors.
REQ-008 SHALL have port clr, input, 1, synchronous clear of the controller state.
REQ-009 SHALL have port u, output, 10, unsigned duty command to the PWM stage.
REQ-010 SHALL have port u_valid, output, 1, one-cycle pulse when u is updated.
REQ-011 SHALL have port busy, output, 1, high while a computation is in flight.
REQ-012 SHALL have port overrun, output, 1, sticky flag: a strobe was dropped.

Function
REQ-013 SHALL implement the incremental law u(k) = u(k-1) + (Kp*(e0-e1) + Ki*e0 + Kd*(e0-2*e1+e2)) >>> FRAC_BITS.
REQ-014 SHALL use one shared signed multiplier, time-multiplexed with one product per cycle.
REQ-015 SHALL use the FSM IDLE -> MUL_P -> MUL_I -> MUL_D -> UPDATE -> IDLE, advancing one state per cycle unconditionally outside IDLE.
REQ-016 In IDLE, when sample_valid=1, SHALL latch ek0..ek2 and kp..kd, clear the accumulator, set busy=1 and go to MUL_P.
REQ-017 Width rules SHALL be: diffP 11b signed, diffD 12b signed, gain zero-extended to 9b signed, accumulator 24b signed, update sum 26b signed.
REQ-018 The shift SHALL be arithmetic, flooring toward negative infinity.
REQ-019 UPDATE SHALL clamp the sum to [0, OUT_MAX], register it to u, and pulse u_valid the next cycle with busy=0.
REQ-020 Latency SHALL be 5 clk edges from the edge sampling sample_valid to u_valid=1 (4 without derivative, see REQ-027).
REQ-021 A sample_valid received while busy=1 SHALL be ignored and SHALL set overrun=1.
REQ-022 A sample_valid in the same cycle as the u_valid pulse SHALL be accepted, since the FSM is already IDLE.
REQ-023 clr=1 in any state SHALL return the FSM to IDLE, set u=0, clear the accumulator, and force busy=0 and u_valid=0 the next cycle; overrun is unchanged.
REQ-024 clr and sample_valid asserted together: clr SHALL win and the strobe SHALL be dropped without setting overrun.
REQ-025 u SHALL hold its value between updates.

Reset
REQ-026 While rst=1, SHALL set u=0, u_valid=0, busy=0, overrun=0, accumulator=0, latched operands=0 and FSM=IDLE; rst overrides clr and sample_valid, and mid-computation the operation is abandoned without u_valid.

Configuration
REQ-027 The macro PID_DERIV_EN SHALL control the derivative term: defined, MUL_D exists and kd is used; undefined, MUL_I goes straight to UPDATE, kd is ignored (port kept) and latency is 4.

Structure
REQ-028 Shared package pid_pkg SHALL hold ERR_W=10, GAIN_W=8, ACC_W=24, U_W=10 and the FSM state enum.
REQ-029 The clamp SHALL be a sub-module pid_sat (26b signed in, OUT_MAX parameter, 10b unsigned out), purely combinational.

Verification
REQ-030 P only: kp=16, ki=kd=0, u=0, ek0=10, ek1=0, strobe -> u_valid 5 cycles later with u=10.
REQ-031 High clamp: u=1020, kp=16, ki=16, ek0=10, ek1=0 -> delta 20, u=1023.
REQ-032 Low clamp: u=5, kp=16, ek0=-10, ek1=0 -> u=0; ek0=-1, kp=1 -> delta floor(-1/16)=-1.
REQ-033 Derivative: kp=ki=0, kd=16, ek0=4, ek1=2, ek2=1, u=0 -> u=1 with PID_DERIV_EN; u=0 in 4 cycles without it.
REQ-034 Overrun: second strobe 2 cycles after the first -> ignored, overrun=1, a single u_valid; back-to-back strobe on the u_valid cycle is accepted.
REQ-035 clr on MUL_I cycle -> no u_valid, u=0, busy=0 next cycle; rst mid-op -> all outputs 0.
